fir_output_capture: RTL and testbench
=====================================

# fir_output_capture

Captures the output sample stream `yn` of the FIR filter into an internal buffer and plays it back through a request/valid read port. It sits at the output end of the filter, the counterpart of the sample source that drives `xn`. After `start` it discards a programmable number of fill-in samples while the filter pipeline settles. It then records a fixed-length window, tracks the signed peak, and hands the window to a reader (checker, DAC feeder or debug port).

## Interface
Parameters:
- `WIDTH`, 32, sample width; samples are two's-complement signed.
- `DEPTH`, 1024, capture window length in samples; power of two, ≥ 2.
- `SKIP`, 29, valid samples discarded after `start`; equals the filter's NCOEFS. 0 is legal.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  arms a capture; honoured only in IDLE.
- `in_valid`  in  1  `yn` carries a new sample this cycle.
- `yn`  in  WIDTH  filter output sample.
- `busy`  out  1  high in SKIP and CAPTURE.
- `done`  out  1  high in READOUT (window complete, readable).
- `peak`  out  WIDTH  signed maximum of the captured window.
- `rd_req`  in  1  request the next buffered sample; honoured only in READOUT.
- `rd_valid`  out  1  `rd_data` valid this cycle.
- `rd_data`  out  WIDTH  buffered sample, in capture order.
- `rd_last`  out  1  with `rd_valid`, marks sample index DEPTH-1.

## Operation
- Four states: IDLE, SKIP, CAPTURE, READOUT.
- IDLE:
  - `start` loads the skip counter with SKIP and clears `wr_ptr`, `rd_ptr` and `peak`.
  - Next state is SKIP, or CAPTURE directly when SKIP = 0.
- SKIP:
  - Each `in_valid` cycle decrements the skip counter; the sample is discarded.
  - The cycle the SKIP-th sample is consumed, next state is CAPTURE.
- CAPTURE:
  - Each `in_valid` cycle writes `yn` to `mem[wr_ptr]` and increments `wr_ptr` (width clog2(DEPTH)).
  - First captured sample loads `peak` unconditionally. Later samples update `peak` only when `$signed(yn) > $signed(peak)`; equal values leave it unchanged.
  - On the DEPTH-th write, `wr_ptr` wraps to 0 and next state is READOUT.
- READOUT:
  - Each `rd_req` cycle reads `mem[rd_ptr]` and increments `rd_ptr`. Back-to-back requests give one sample per cycle.
  - When the request for index DEPTH-1 is accepted, next state is IDLE.
  - `peak` holds its value until the next `start`.
- Ignored inputs:
  - `start` outside IDLE, including while `start` is held high.
  - `in_valid` in IDLE and READOUT; samples are dropped, with no overflow.
  - `rd_req` outside READOUT; no `rd_valid` results.
- Simultaneous events: `start` and `in_valid` in the same IDLE cycle; that sample is not counted. Counting begins the cycle after entering SKIP/CAPTURE.
- Reset mid-operation returns to IDLE with all pointers, counters and outputs cleared. Memory contents are not cleared and are never exposed before being rewritten.

## Timing
- Reset values: `busy`=0, `done`=0, `peak`=0, `rd_valid`=0, `rd_data`=0, `rd_last`=0; state IDLE.
- `busy` rises the cycle after `start` is accepted.
- `done`:
  - Rises, and `busy` falls, the cycle after the DEPTH-th sample write.
  - Falls the cycle after the final read request.
- `peak` is registered; it reflects a sample one cycle after that sample's `in_valid`.
- Read latency is 1 cycle: `rd_req` at cycle t gives `rd_valid`=1 with `rd_data` and `rd_last` at t+1.
- `rd_valid` is a one-cycle pulse per request. `rd_data` holds its last value while `rd_valid`=0.
- Last sample: the final `rd_valid`/`rd_last` pulse occurs in the first IDLE cycle. A `start` in that same cycle is accepted.
- Memory is a single synchronous-read RAM: one write port (CAPTURE) and one read port (READOUT), never active together.
- Minimum start-to-done: SKIP + DEPTH + 1 cycles with continuous `in_valid`.

## Test plan
All scenarios use bench parameters WIDTH=32, DEPTH=8, SKIP=3.
- Reset, then idle 5 cycles → all outputs 0; `rd_req` pulses produce no `rd_valid`.
- `start`, then continuous `in_valid` with `yn`=1,2,…,11:
  - `busy` high 11 cycles; `done` rises the cycle after `yn`=11.
  - 8 back-to-back `rd_req` → `rd_data`=4..11, `rd_last` only with 11, `peak`=11.
- Signed data with gapped `in_valid` (every 3rd cycle), after 3 skipped samples: -5, -1, -7, -1, -100, -2, -3, -9 → `peak`=0xFFFF_FFFF (-1); readback is exact and in order.
- Reset asserted after 4 captured samples → next cycle `busy`=0, `peak`=0. A new `start` with 11 samples 20..30 reads back 23..30.
- `start` held high through a full capture/readout → no restart mid-run. A second capture begins in the cycle that `rd_last` is asserted.
- SKIP=0, DEPTH=2 build, `yn`=7, 9 → `done` after 2 samples; readback 7, 9; `peak`=9.

Source files
------------

// File: rtl/fir_output_capture.sv
// Output-side capture buffer for the FIR filter: skips pipeline fill-in samples,
// records a fixed window while tracking its signed peak, then plays it back on request.
module fir_output_capture #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int SKIP  = 29
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] yn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] peak,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SKIP    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_READOUT = 2'd3;

  logic [1:0]       r_state;
  logic [SW-1:0]    r_skipCnt;
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [WIDTH-1:0] r_peak;
  logic             r_rdValid;
  logic             r_rdLast;
  logic [WIDTH-1:0] r_rdData;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_wrEn;
  logic w_rdEn;
  logic w_lastWr;
  logic w_lastRd;

  assign w_wrEn   = (r_state == S_CAPTURE) && in_valid;
  assign w_rdEn   = (r_state == S_READOUT) && rd_req;
  assign w_lastWr = w_wrEn && (r_wrPtr == AW'(DEPTH - 1));
  assign w_lastRd = w_rdEn && (r_rdPtr == AW'(DEPTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_skipCnt <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_peak    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_skipCnt <= SW'(SKIP);
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_peak    <= '0;
            r_state   <= (SKIP == 0) ? S_CAPTURE : S_SKIP;
          end
        end
        S_SKIP: begin
          if (in_valid) begin
            r_skipCnt <= r_skipCnt - SW'(1);
            if (r_skipCnt == SW'(1)) r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_wrEn) begin
            r_wrPtr <= r_wrPtr + AW'(1);
            // Write pointer at zero marks the first sample, which seeds the peak.
            if ((r_wrPtr == '0) || ($signed(yn) > $signed(r_peak))) r_peak <= yn;
            if (w_lastWr) r_state <= S_READOUT;
          end
        end
        S_READOUT: begin
          if (w_rdEn) begin
            r_rdPtr <= r_rdPtr + AW'(1);
            if (w_lastRd) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer storage is deliberately not reset; reads only reach rewritten entries.
  always_ff @(posedge clock) begin
    if (w_wrEn) r_mem[r_wrPtr] <= yn;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdValid <= 1'b0;
      r_rdLast  <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_rdValid <= w_rdEn;
      r_rdLast  <= w_lastRd;
      if (w_rdEn) r_rdData <= r_mem[r_rdPtr];
    end
  end

  assign busy     = (r_state == S_SKIP) || (r_state == S_CAPTURE);
  assign done     = (r_state == S_READOUT);
  assign peak     = r_peak;
  assign rd_valid = r_rdValid;
  assign rd_data  = r_rdData;
  assign rd_last  = r_rdLast;

endmodule

// File: tb/tb_fir_output_capture.sv
// Scoreboard bench for fir_output_capture: a window/peak model predicts readback,
// and per-DUT monitors pop expectations whenever rd_valid is seen.
module tb_fir_output_capture;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int SKIP  = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rdExp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        start, inValid, rdReq;
  logic [31:0] yn;
  logic        busy, done, rdValid, rdLast;
  logic [31:0] peak, rdData;

  logic        bStart, bInValid, bRdReq;
  logic [31:0] bYn;
  logic        bBusy, bDone, bRdValid, bRdLast;
  logic [31:0] bPeak, bRdData;

  int          nChecks = 0;
  int          nFails  = 0;
  int          busyTotal = 0;
  bit          holdStart = 1'b0;
  rdExp_t      expQ[$];
  rdExp_t      expQB[$];
  rdExp_t      monA, monB;
  logic [31:0] stimQ[$];
  logic [31:0] expPeak;

  fir_output_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKIP(SKIP)) dutA (
    .clock(clock), .reset(reset), .start(start), .in_valid(inValid), .yn(yn),
    .busy(busy), .done(done), .peak(peak), .rd_req(rdReq),
    .rd_valid(rdValid), .rd_data(rdData), .rd_last(rdLast)
  );

  fir_output_capture #(.WIDTH(32), .DEPTH(2), .SKIP(0)) dutB (
    .clock(clock), .reset(reset), .start(bStart), .in_valid(bInValid), .yn(bYn),
    .busy(bBusy), .done(bDone), .peak(bPeak), .rd_req(bRdReq),
    .rd_valid(bRdValid), .rd_data(bRdData), .rd_last(bRdLast)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (busy) busyTotal++;
  end

  always @(negedge clock) begin
    if (rdValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedRdValid", 32'(rdValid), 32'd0);
      end else begin
        monA = expQ.pop_front();
        checkOutput("rdData", rdData, monA.data);
        checkOutput("rdLast", 32'(rdLast), 32'(monA.last));
      end
    end else if (rdLast) begin
      checkOutput("rdLastWithoutValid", 32'(rdLast), 32'd0);
    end
  end

  always @(negedge clock) begin
    if (bRdValid) begin
      if (expQB.size() == 0) begin
        checkOutput("bUnexpectedRdValid", 32'(bRdValid), 32'd0);
      end else begin
        monB = expQB.pop_front();
        checkOutput("bRdData", bRdData, monB.data);
        checkOutput("bRdLast", 32'(bRdLast), 32'(monB.last));
      end
    end
  end

  // Reference: the window is the DEPTH samples after the first SKIP, peak is its signed max.
  task automatic computeModel;
    expPeak = stimQ[SKIP];
    for (int i = 1; i < DEPTH; i++) begin
      if ($signed(stimQ[SKIP + i]) > $signed(expPeak)) expPeak = stimQ[SKIP + i];
    end
  endtask

  task automatic applyStimulus(input int gapMode, input bit doStart, input bit expectDone);
    int g;
    if (doStart) begin
      start = 1'b1;
      tick();
      if (!holdStart) start = 1'b0;
    end
    for (int i = 0; i < stimQ.size(); i++) begin
      inValid = 1'b1;
      yn = stimQ[i];
      tick();
      inValid = 1'b0;
      yn = $urandom;
      if (expectDone) begin
        if (i == stimQ.size() - 1) begin
          checkOutput("doneAtWindowEnd", 32'(done), 32'd1);
          checkOutput("busyAtWindowEnd", 32'(busy), 32'd0);
        end else begin
          checkOutput("busyDuringCapture", 32'(busy), 32'd1);
          checkOutput("doneDuringCapture", 32'(done), 32'd0);
        end
      end
      if (i < stimQ.size() - 1) begin
        g = (gapMode < 0) ? int'($urandom_range(0, 2)) : gapMode;
        repeat (g) tick();
      end
    end
  endtask

  task automatic readWindow(input bit randGaps);
    rdExp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      rdReq = 1'b1;
      e.data = stimQ[SKIP + i];
      e.last = (i == DEPTH - 1);
      expQ.push_back(e);
      tick();
      rdReq = 1'b0;
      if (i < DEPTH - 1) begin
        checkOutput("doneDuringRead", 32'(done), 32'd1);
        if (randGaps) begin
          repeat ($urandom_range(0, 2)) begin
            inValid = 1'($urandom);
            yn = $urandom;
            tick();
          end
          inValid = 1'b0;
        end
      end
    end
    checkOutput("doneAfterRead", 32'(done), 32'd0);
    for (int k = 0; k < 5 && expQ.size() > 0; k++) tick();
    checkOutput("readDrain", 32'(expQ.size()), 32'd0);
  endtask

  task automatic idleNoise(input int n);
    repeat (n) begin
      rdReq = 1'($urandom);
      inValid = 1'($urandom);
      yn = $urandom;
      tick();
    end
    rdReq = 1'b0;
    inValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sv[11];
    int b0;
    rdExp_t e;
    reset = 1'b1;
    start = 1'b0; inValid = 1'b0; rdReq = 1'b0; yn = '0;
    bStart = 1'b0; bInValid = 1'b0; bRdReq = 1'b0; bYn = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle: requests and samples are ignored, outputs stay at reset values
    idleNoise(5);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetPeak", peak, 32'd0);
    checkOutput("resetRdValid", 32'(rdValid), 32'd0);
    checkOutput("resetRdData", rdData, 32'd0);
    checkOutput("resetRdLast", 32'(rdLast), 32'd0);

    // Ramp 1..11, continuous
    stimQ.delete();
    for (int i = 1; i <= 11; i++) stimQ.push_back(32'(i));
    b0 = busyTotal;
    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("busyCycles", 32'(busyTotal - b0), 32'd11);
    computeModel();
    checkOutput("rampPeak", peak, expPeak);
    checkOutput("rampPeakConst", peak, 32'd11);
    readWindow(1'b0);
    idleNoise(3);

    // Signed samples, in_valid every third cycle
    sv = '{50, 60, 70, -5, -1, -7, -1, -100, -2, -3, -9};
    stimQ.delete();
    for (int i = 0; i < 11; i++) stimQ.push_back(32'(sv[i]));
    applyStimulus(2, 1'b1, 1'b1);
    computeModel();
    checkOutput("signedPeak", peak, expPeak);
    checkOutput("signedPeakConst", peak, 32'hFFFF_FFFF);
    readWindow(1'b1);

    // Reset in the middle of a capture
    stimQ.delete();
    for (int i = 0; i < 7; i++) stimQ.push_back(32'(100 + i));
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("busyBeforeReset", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("busyAfterReset", 32'(busy), 32'd0);
    checkOutput("peakAfterReset", peak, 32'd0);
    checkOutput("doneAfterReset", 32'(done), 32'd0);
    stimQ.delete();
    for (int i = 20; i <= 30; i++) stimQ.push_back(32'(i));
    applyStimulus(0, 1'b1, 1'b1);
    computeModel();
    checkOutput("postResetPeak", peak, expPeak);
    readWindow(1'b0);

    // start held high across a whole run; restart lands on the rd_last cycle
    holdStart = 1'b1;
    stimQ.delete();
    for (int i = 0; i < SKIP + DEPTH; i++) stimQ.push_back($urandom);
    applyStimulus(1, 1'b1, 1'b1);
    computeModel();
    checkOutput("holdPeak", peak, expPeak);
    readWindow(1'b1);
    checkOutput("restartOnLast", 32'(busy), 32'd1);
    start = 1'b0;
    holdStart = 1'b0;
    stimQ.delete();
    for (int i = 0; i < SKIP + DEPTH; i++) stimQ.push_back($urandom);
    applyStimulus(0, 1'b0, 1'b1);
    computeModel();
    checkOutput("restartPeak", peak, expPeak);
    readWindow(1'b0);

    // Randomized runs; narrow value range makes ties with the peak likely
    for (int r = 0; r < 6; r++) begin
      idleNoise(int'($urandom_range(1, 4)));
      stimQ.delete();
      for (int i = 0; i < SKIP + DEPTH; i++)
        stimQ.push_back((r % 2 == 0) ? 32'(int'($urandom_range(0, 20)) - 10) : $urandom);
      applyStimulus(-1, 1'b1, 1'b1);
      computeModel();
      checkOutput("randPeak", peak, expPeak);
      readWindow(1'b1);
    end

    // DEPTH=2, SKIP=0 instance
    bStart = 1'b1;
    tick();
    bStart = 1'b0;
    checkOutput("bBusyAfterStart", 32'(bBusy), 32'd1);
    bInValid = 1'b1; bYn = 32'd7;
    tick();
    checkOutput("bDoneAfterOne", 32'(bDone), 32'd0);
    bYn = 32'd9;
    tick();
    bInValid = 1'b0;
    checkOutput("bDoneAfterTwo", 32'(bDone), 32'd1);
    checkOutput("bPeak", bPeak, 32'd9);
    e.data = 32'd7; e.last = 1'b0; expQB.push_back(e);
    bRdReq = 1'b1;
    tick();
    e.data = 32'd9; e.last = 1'b1; expQB.push_back(e);
    tick();
    bRdReq = 1'b0;
    checkOutput("bDoneAfterRead", 32'(bDone), 32'd0);
    for (int k = 0; k < 5 && expQB.size() > 0; k++) tick();
    checkOutput("bReadDrain", 32'(expQB.size()), 32'd0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
